universal_shift_register: RTL and testbench

Parametrised N-bit register with synchronous active-low clear, parallel load, bidirectional serial shift and a shift-progress counter. Next generation of the single-bit clearable D flip-flop, and the general storage/serialiser element for lab datapaths (serial-to-parallel conversion, bit-serial arithmetic operand registers, LFSR-style experiments). One clock domain; every output is registered or is a direct function of registered state.

---
 rtl/universal_shift_register.sv | 85 ++++++++
 tb/tb_universal_shift_register.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - N-bit universal shift register with load, bidirectional shift and shift-progress counter
// Optional feature macro: USR_ROTATE_EN (adds the rotate input for circular shifts).
module universal_shift_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                       clock,
    input  logic                       not_clear,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       sin_right,
    input  logic                       sin_left,
`ifdef USR_ROTATE_EN
    input  logic                       rotate,
`endif
    output logic [WIDTH-1:0]           q,
    output logic                       sout_right,
    output logic                       sout_left,
    output logic [$clog2(WIDTH+1)-1:0] shift_count,
    output logic                       shift_done
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] COUNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic          fill_right;
    logic          fill_left;
    logic [CW-1:0] count_next;
    logic          done_next;

    always_comb begin
`ifdef USR_ROTATE_EN
        fill_right = rotate ? q[0]       : sin_right;
        fill_left  = rotate ? q[WIDTH-1] : sin_left;
`else
        fill_right = sin_right;
        fill_left  = sin_left;
`endif
        // Counter saturates at WIDTH; the pulse fires only on the WIDTH-1 -> WIDTH step.
        count_next = (shift_count == COUNT_MAX) ? COUNT_MAX : shift_count + 1'b1;
        done_next  = (shift_count == COUNT_LAST);
    end

    always_ff @(posedge clock) begin
        if (!not_clear) begin
            q           <= RESET_VALUE;
            shift_count <= '0;
            shift_done  <= 1'b0;
        end else begin
            case (mode)
                MODE_HOLD: begin
                    shift_done <= 1'b0;
                end
                MODE_RIGHT: begin
                    q           <= {fill_right, q[WIDTH-1:1]};
                    shift_count <= count_next;
                    shift_done  <= done_next;
                end
                MODE_LEFT: begin
                    q           <= {q[WIDTH-2:0], fill_left};
                    shift_count <= count_next;
                    shift_done  <= done_next;
                end
                MODE_LOAD: begin
                    q           <= d;
                    shift_count <= '0;
                    shift_done  <= 1'b0;
                end
                default: begin
                    shift_done <= 1'b0;
                end
            endcase
        end
    end

    assign sout_right = q[0];
    assign sout_left  = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - table-driven self-checking bench for universal_shift_register
module tb_universal_shift_register;

    localparam int WIDTH = 8;

    logic             clock;
    logic             not_clear;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_right;
    logic             sin_left;
    logic             rotate;
    logic [WIDTH-1:0] q;
    logic             sout_right;
    logic             sout_left;
    logic [3:0]       shift_count;
    logic             shift_done;

    int total;
    int bad;

    universal_shift_register #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .not_clear  (not_clear),
        .mode       (mode),
        .d          (d),
        .sin_right  (sin_right),
        .sin_left   (sin_left),
`ifdef USR_ROTATE_EN
        .rotate     (rotate),
`endif
        .q          (q),
        .sout_right (sout_right),
        .sout_left  (sout_left),
        .shift_count(shift_count),
        .shift_done (shift_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       nc;
        logic [1:0] md;
        logic [7:0] dd;
        logic       sr;
        logic       sl;
        logic [7:0] eq;
        logic [3:0] ecnt;
        logic       edone;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic nc, input logic [1:0] md, input logic [7:0] dd,
                                input logic sr, input logic sl, input logic [7:0] eq,
                                input logic [3:0] ecnt, input logic edone);
        vec_t v;
        v.nc = nc; v.md = md; v.dd = dd; v.sr = sr; v.sl = sl;
        v.eq = eq; v.ecnt = ecnt; v.edone = edone;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic nc, input logic [1:0] md, input logic [7:0] dd,
                        input logic sr, input logic sl);
        not_clear = nc; mode = md; d = dd; sin_right = sr; sin_left = sl;
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] eq, input logic [3:0] ecnt,
                             input logic edone);
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".count"}, 32'(shift_count), 32'(ecnt));
        check({tag, ".done"}, 32'(shift_done), 32'(edone));
        check({tag, ".sout_r"}, 32'(sout_right), 32'(eq[0]));
        check({tag, ".sout_l"}, 32'(sout_left), 32'(eq[7]));
    endtask

    initial begin
        logic [7:0] rq;
        total = 0; bad = 0;
        not_clear = 1'b0; mode = 2'b00; d = '0; sin_right = 1'b0; sin_left = 1'b0; rotate = 1'b0;

        // clear, then hold with noisy d/serial inputs (sampled only when selected)
        add(0, 2'b01, 8'h5A, 1, 1, 8'h00, 0, 0);
        add(1, 2'b00, 8'hFF, 1, 1, 8'h00, 0, 0);
        add(1, 2'b00, 8'h33, 0, 1, 8'h00, 0, 0);
        add(1, 2'b00, 8'hC3, 1, 0, 8'h00, 0, 0);
        // load A5, shift right x8 with sin_right=1
        add(1, 2'b11, 8'hA5, 0, 0, 8'hA5, 0, 0);
        add(1, 2'b01, 8'h00, 1, 0, 8'hD2, 1, 0);
        add(1, 2'b01, 8'h00, 1, 0, 8'hE9, 2, 0);
        add(1, 2'b01, 8'h00, 1, 0, 8'hF4, 3, 0);
        add(1, 2'b01, 8'h00, 1, 0, 8'hFA, 4, 0);
        add(1, 2'b01, 8'h00, 1, 0, 8'hFD, 5, 0);
        add(1, 2'b01, 8'h00, 1, 0, 8'hFE, 6, 0);
        add(1, 2'b01, 8'h00, 1, 0, 8'hFF, 7, 0);
        add(1, 2'b01, 8'h00, 1, 0, 8'hFF, 8, 1);
        add(1, 2'b00, 8'h00, 0, 0, 8'hFF, 8, 0);
        // load 81, shift left x10 with sin_left=0; saturation after the 8th
        add(1, 2'b11, 8'h81, 0, 0, 8'h81, 0, 0);
        add(1, 2'b10, 8'h00, 0, 0, 8'h02, 1, 0);
        add(1, 2'b10, 8'h00, 0, 0, 8'h04, 2, 0);
        add(1, 2'b10, 8'h00, 0, 0, 8'h08, 3, 0);
        add(1, 2'b10, 8'h00, 0, 0, 8'h10, 4, 0);
        add(1, 2'b10, 8'h00, 0, 0, 8'h20, 5, 0);
        add(1, 2'b10, 8'h00, 0, 0, 8'h40, 6, 0);
        add(1, 2'b10, 8'h00, 0, 0, 8'h80, 7, 0);
        add(1, 2'b10, 8'h00, 0, 0, 8'h00, 8, 1);
        add(1, 2'b10, 8'h00, 0, 0, 8'h00, 8, 0);
        add(1, 2'b10, 8'h00, 0, 0, 8'h00, 8, 0);
        // load 3C, shift x4, clear while shifting
        add(1, 2'b11, 8'h3C, 0, 0, 8'h3C, 0, 0);
        add(1, 2'b01, 8'h00, 0, 0, 8'h1E, 1, 0);
        add(1, 2'b01, 8'h00, 0, 0, 8'h0F, 2, 0);
        add(1, 2'b01, 8'h00, 0, 0, 8'h07, 3, 0);
        add(1, 2'b01, 8'h00, 0, 0, 8'h03, 4, 0);
        add(0, 2'b01, 8'h00, 1, 1, 8'h00, 0, 0);
        // shift x5, reload 11, then 8 mixed-direction shifts
        add(1, 2'b10, 8'h00, 0, 1, 8'h01, 1, 0);
        add(1, 2'b10, 8'h00, 0, 1, 8'h03, 2, 0);
        add(1, 2'b10, 8'h00, 0, 1, 8'h07, 3, 0);
        add(1, 2'b10, 8'h00, 0, 1, 8'h0F, 4, 0);
        add(1, 2'b10, 8'h00, 0, 1, 8'h1F, 5, 0);
        add(1, 2'b11, 8'h11, 0, 0, 8'h11, 0, 0);
        add(1, 2'b01, 8'h00, 0, 0, 8'h08, 1, 0);
        add(1, 2'b01, 8'h00, 0, 0, 8'h04, 2, 0);
        add(1, 2'b01, 8'h00, 0, 0, 8'h02, 3, 0);
        add(1, 2'b01, 8'h00, 0, 0, 8'h01, 4, 0);
        add(1, 2'b10, 8'h00, 0, 1, 8'h03, 5, 0);
        add(1, 2'b10, 8'h00, 0, 1, 8'h07, 6, 0);
        add(1, 2'b10, 8'h00, 0, 1, 8'h0F, 7, 0);
        add(1, 2'b10, 8'h00, 0, 1, 8'h1F, 8, 1);
        add(1, 2'b00, 8'h00, 0, 0, 8'h1F, 8, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].nc, vecs[i].md, vecs[i].dd, vecs[i].sr, vecs[i].sl);
            check_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ecnt, vecs[i].edone);
        end

        // clear arriving on the cycle that would have completed the sequence
        step(1, 2'b11, 8'hAA, 0, 0);
        check_all("abort.load", 8'hAA, 0, 0);
        rq = 8'hAA;
        for (int i = 1; i <= 7; i++) begin
            step(1, 2'b01, 8'h00, 0, 0);
            rq = {1'b0, rq[7:1]};
            check_all($sformatf("abort.sh%0d", i), rq, 4'(i), 0);
        end
        step(0, 2'b01, 8'h00, 1, 0);
        check_all("abort.clr", 8'h00, 0, 0);
        step(1, 2'b00, 8'h00, 0, 0);
        check_all("abort.hold", 8'h00, 0, 0);

`ifdef USR_ROTATE_EN
        step(1, 2'b11, 8'h81, 0, 0);
        rotate = 1'b1;
        rq = 8'h81;
        for (int i = 1; i <= 8; i++) begin
            step(1, 2'b01, 8'h00, 0, 0);
            rq = {rq[0], rq[7:1]};
            check_all($sformatf("rot.sh%0d", i), rq, 4'(i), (i == 8));
        end
        check("rot.final", 32'(q), 32'h81);
        rotate = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
